alu_scheduler: RTL and testbench
================================

Name: alu_scheduler

Overview:
Shares the single combinational `alu` (OPCODE/DATA_A/DATA_B -> DATA_OUT) between two requesters.
- Arbitrates round-robin and latches the winning operation.
- Drives the ALU from registers and captures its result.
- Returns the result on a valid/ready response channel tagged with the requester ID.
- Intercepts divide-by-zero so the ALU's undefined output never reaches a requester.

Parameters:
WIDTH, 8, operand/result width (matches alu DATA_A/DATA_B/DATA_OUT)
OPW, 2, opcode width (matches alu OPCODE)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ0_VALID  in  1  requester 0 has an operation
REQ0_READY  out  1  requester 0 operation accepted this cycle
REQ0_OPCODE  in  OPW  requester 0 opcode
REQ0_DATA_A  in  WIDTH  requester 0 operand A
REQ0_DATA_B  in  WIDTH  requester 0 operand B
REQ1_VALID / REQ1_READY / REQ1_OPCODE / REQ1_DATA_A / REQ1_DATA_B  same as above for requester 1
ALU_OPCODE  out  OPW  to alu OPCODE
ALU_DATA_A  out  WIDTH  to alu DATA_A
ALU_DATA_B  out  WIDTH  to alu DATA_B
ALU_DATA_OUT  in  WIDTH  from alu DATA_OUT
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumer ready
RSP_DATA  out  WIDTH  result
RSP_ID  out  1  requester that issued the operation
RSP_ERR  out  1  divide-by-zero flag

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0; operand/opcode registers 0.
  - Round-robin pointer LAST=1, so requester 0 wins the first tie.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any REQx_VALID, grant one requester. A lone requester always wins; on a tie the winner is the requester not equal to LAST.
  - REQg_READY=1 combinationally for exactly that cycle (valid&ready handshake). Latch opcode, A, B and ID=g; go EXEC.
  - Otherwise stay in IDLE.
- REQx_READY is never asserted outside IDLE.
- ALU_OPCODE, ALU_DATA_A and ALU_DATA_B are always driven from the latched registers, never from the request ports.
- EXEC (one cycle): register the result and go RESP.
  - If opcode==2'b11 and latched B==0: RSP_DATA={WIDTH{1'b1}}, RSP_ERR=1.
  - Else RSP_DATA=ALU_DATA_OUT, RSP_ERR=0.
  - Arithmetic wraps mod 2^WIDTH exactly as the alu does; no checks beyond divide-by-zero.
- RESP:
  - RSP_VALID=1 with RSP_DATA, RSP_ID and RSP_ERR stable until RSP_READY.
  - On RSP_VALID&RSP_READY: LAST=ID, RSP_VALID=0 next cycle, go IDLE.
- Latency and throughput:
  - Request accepted at edge N gives RSP_VALID high from cycle N+2.
  - Maximum throughput is one operation per 3 cycles with RSP_READY held high.
- Back-pressure: a requester's VALID held during EXEC/RESP is not accepted; no queueing.
- Reset mid-operation discards any in-flight operation: no response is emitted and the pointer returns to LAST=1.
- Requester inputs changing after acceptance have no effect on the in-flight operation.

Optional Feature:
ALU_SCHED_STATS_EN
- Defined: adds output ports STAT_GNT0 and STAT_GNT1 (16 bits each), plus STAT_DIV0 (8 bits).
  - STAT_GNT0/STAT_GNT1 increment on each accepted request from requester 0/1.
  - STAT_DIV0 increments on each divide-by-zero interception.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
  - FSM state encoding: IDLE, EXEC, RESP;
  - DIV0_RESULT pattern.
- Sub-module rr_arb2 is natural: inputs REQ[1:0] and LAST; outputs GNT_VALID and GNT_ID. It is purely combinational and reusable for other shared units.

Test Plan:
- REQ0 ADD 15,10 alone, RSP_READY=1 -> REQ0_READY pulses 1 cycle; RSP_VALID 2 cycles later with RSP_DATA=25, RSP_ID=0, RSP_ERR=0.
- REQ0 SUB 20,5 and REQ1 MUL 4,5 asserted together from reset -> first response DATA=15 ID=0, second DATA=20 ID=1; no READY to REQ1 until the FSM returns to IDLE.
- Both requesters held valid for 6 operations -> RSP_ID sequence 0,1,0,1,0,1.
- REQ1 DIV 20,0 -> RSP_DATA=8'hFF, RSP_ERR=1, RSP_ID=1; then DIV 20,4 -> RSP_DATA=5, RSP_ERR=0.
- RSP_READY held low 5 cycles during RESP -> RSP_VALID and RSP_DATA stable, both REQx_READY stay 0; release -> single handshake, return to IDLE.
- RST_N pulled low during EXEC of ADD 200,100 -> all outputs 0 immediately; no response after release; next tie grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg: opcodes, scheduler FSM states and the divide-by-zero    |
// | result pattern shared by alu_scheduler.                          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // All-ones pattern; users take the low WIDTH bits (WIDTH up to 64).
  localparam logic [63:0] DIV0_RESULT = '1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2: combinational two-way round-robin arbiter. On a tie the  |
// | requester other than LAST wins.                                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_scheduler: shares one combinational ALU between two          |
// | requesters with round-robin arbitration and a valid/ready        |
// | response channel. Optional grant/div0 counters: ALU_SCHED_STATS_EN|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_SCHED_STATS_EN
  output logic [15:0]      stat_gnt0,
  output logic [15:0]      stat_gnt1,
  output logic [7:0]       stat_div0,
`endif
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_data_a,
  input  logic [WIDTH-1:0] req0_data_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_data_a,
  input  logic [WIDTH-1:0] req1_data_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_data_a,
  output logic [WIDTH-1:0] alu_data_b,
  input  logic [WIDTH-1:0] alu_data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [OPW-1:0]   opc_q, opc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic gnt_valid, gnt_id, accept, div0;

  rr_arb2 u_arb (
    .req       ({req1_valid, req0_valid}),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Readies are gated by rst_n so they stay low while reset is asserted.
  assign accept     = (state_q == ST_IDLE) && gnt_valid && rst_n;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;
  assign div0       = (opc_q == OPW'(OP_DIV)) && (b_q == '0);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    opc_d       = opc_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = gnt_id;
          opc_d   = gnt_id ? req1_opcode : req0_opcode;
          a_d     = gnt_id ? req1_data_a : req0_data_a;
          b_d     = gnt_id ? req1_data_b : req0_data_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = div0 ? DIV0_RESULT[WIDTH-1:0] : alu_data_out;
        rsp_err_d   = div0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = id_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      opc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      opc_q       <= opc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_opcode = opc_q;
  assign alu_data_a = a_q;
  assign alu_data_b = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = id_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [7:0]  div0_cnt_q, div0_cnt_d;

  always_comb begin
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    div0_cnt_d = div0_cnt_q;
    if (req0_ready && (gnt0_q != '1)) gnt0_d = gnt0_q + 16'd1;
    if (req1_ready && (gnt1_q != '1)) gnt1_d = gnt1_q + 16'd1;
    if ((state_q == ST_EXEC) && div0 && (div0_cnt_q != '1)) div0_cnt_d = div0_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q     <= '0;
      gnt1_q     <= '0;
      div0_cnt_q <= '0;
    end else begin
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      div0_cnt_q <= div0_cnt_d;
    end
  end

  assign stat_gnt0 = gnt0_q;
  assign stat_gnt1 = gnt1_q;
  assign stat_div0 = div0_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_scheduler: self-checking bench with a behavioural ALU and |
// | a transaction-level reference model of alu_scheduler.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_alu_scheduler;

  localparam int WIDTH = 8;
  localparam int OPW   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [OPW-1:0]   req0_opcode = '0, req1_opcode = '0;
  logic [WIDTH-1:0] req0_data_a = '0, req0_data_b = '0;
  logic [WIDTH-1:0] req1_data_a = '0, req1_data_b = '0;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] alu_data_a, alu_data_b, alu_data_out;
  logic             rsp_valid, rsp_id, rsp_err;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1;
  logic [7:0]  stat_div0;
  int exp_g0 = 0, exp_g1 = 0, exp_d0 = 0;
`endif

  int checks = 0;
  int failures = 0;
  bit model_last = 1'b1;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; divide-by-zero yields a garbage value.
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_data_out = alu_data_a + alu_data_b;
      2'b01:   alu_data_out = alu_data_a - alu_data_b;
      2'b10:   alu_data_out = alu_data_a * alu_data_b;
      default: alu_data_out = (alu_data_b == 0) ? 8'h5A : alu_data_a / alu_data_b;
    endcase
  end

  alu_scheduler #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ALU_SCHED_STATS_EN
    .stat_gnt0    (stat_gnt0),
    .stat_gnt1    (stat_gnt1),
    .stat_div0    (stat_div0),
`endif
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_opcode  (req0_opcode),
    .req0_data_a  (req0_data_a),
    .req0_data_b  (req0_data_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_opcode  (req1_opcode),
    .req1_data_a  (req1_data_a),
    .req1_data_b  (req1_data_b),
    .alu_opcode   (alu_opcode),
    .alu_data_a   (alu_data_a),
    .alu_data_b   (alu_data_b),
    .alu_data_out (alu_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    bit         id;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] d, output logic e);
    int r;
    e = 1'b0;
    case (op)
      2'b00:   r = (int'(a) + int'(b)) % 256;
      2'b01:   r = (int'(a) - int'(b) + 256) % 256;
      2'b10:   r = (int'(a) * int'(b)) % 256;
      default: begin
        if (b == 0) begin r = 255; e = 1'b1; end
        else r = int'(a) / int'(b);
      end
    endcase
    d = 8'(r);
  endfunction

  function automatic logic rdy(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_opcode = op; req1_data_a = a; req1_data_b = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_data_a = a; req0_data_b = b;
    end
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data_a = 8'hEE;
    req0_data_b = 8'h00;
    req1_data_a = 8'hEE;
    req1_data_b = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
`ifdef ALU_SCHED_STATS_EN
    exp_g0 = 0; exp_g1 = 0; exp_d0 = 0;
`endif
  endtask

  task automatic note_grant(input bit id, input logic e);
`ifdef ALU_SCHED_STATS_EN
    if (id) exp_g1++; else exp_g0++;
    if (e) exp_d0++;
`endif
  endtask

  // Called at the negedge of the EXEC cycle; consumes one response.
  task automatic collect(input bit id, input logic [7:0] d, input logic e, input int hold);
    int n = 0;
    logic [7:0] held;
    while (!rsp_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, 1);
    check("rsp_data", rsp_data, d);
    check("rsp_id", rsp_id, id);
    check("rsp_err", rsp_err, e);
    held = rsp_data;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", rsp_valid, 1);
        check("hold_data", rsp_data, held);
        check("hold_ready01", {req1_ready, req0_ready}, 0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("rsp_valid_drop", rsp_valid, 0);
    model_last = id;
  endtask

  task automatic single_op(input vec_t v, input int hold);
    int n = 0;
    @(negedge clk);
    set_req(v.id, v.op, v.a, v.b);
    #1;
    while (!rdy(v.id) && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_wait", n, 0);
    check("other_ready", rdy(!v.id), 0);
    note_grant(v.id, v.e);
    @(negedge clk);
    check("ready_in_exec", rdy(v.id), 0);
    clear_reqs();
    collect(v.id, v.d, v.e, hold);
  endtask

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic e, a0, b0, a1, b1;
    int n;
    bit w;
    int pat;
    logic [1:0] op0, op1;
    logic [7:0] x0, y0, x1, y1;

    tbl[0] = '{1'b0, 2'b00, 8'd15,  8'd10, 8'd25,  1'b0};
    tbl[1] = '{1'b0, 2'b01, 8'd20,  8'd5,  8'd15,  1'b0};
    tbl[2] = '{1'b1, 2'b10, 8'd4,   8'd5,  8'd20,  1'b0};
    tbl[3] = '{1'b1, 2'b11, 8'd20,  8'd0,  8'hFF,  1'b1};
    tbl[4] = '{1'b1, 2'b11, 8'd20,  8'd4,  8'd5,   1'b0};
    tbl[5] = '{1'b0, 2'b00, 8'd200, 8'd100, 8'd44, 1'b0};
    tbl[6] = '{1'b1, 2'b01, 8'd3,   8'd5,  8'hFE,  1'b0};
    tbl[7] = '{1'b0, 2'b10, 8'd16,  8'd17, 8'h10,  1'b0};
    tbl[8] = '{1'b0, 2'b11, 8'd7,   8'd0,  8'hFF,  1'b1};
    tbl[9] = '{1'b0, 2'b11, 8'd255, 8'd16, 8'd15,  1'b0};

    // Reset state, with a request pending that must not be granted.
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id_err", {rsp_id, rsp_err}, 0);
    check("rst_alu_regs", {alu_opcode, alu_data_a, alu_data_b}, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) single_op(tbl[i], (i == 3) ? 5 : 0);

    // Tie from reset: requester 0 first, requester 1 waits for IDLE.
    do_reset();
    set_req(1'b0, 2'b01, 8'd20, 8'd5);
    set_req(1'b1, 2'b10, 8'd4, 8'd5);
    #1;
    check("tie_ready", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 1'b0;
    check("tie_r1_exec", req1_ready, 0);
    @(negedge clk);
    check("tie_r1_resp", req1_ready, 0);
    check("tie_first", {rsp_id, rsp_data}, {1'b0, 8'd15});
    @(negedge clk);
    #1;
    check("tie_r1_idle", req1_ready, 1);
    @(negedge clk);
    clear_reqs();
    collect(1'b1, 8'd20, 1'b0, 0);

    // Both held valid: alternating grants at one op per 3 cycles.
    do_reset();
    set_req(1'b0, 2'b00, 8'd1, 8'd2);
    set_req(1'b1, 2'b00, 8'd3, 8'd4);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!rsp_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("rr_id", rsp_id, k % 2);
      check("rr_data", rsp_data, (k % 2) ? 8'd7 : 8'd3);
      if (k > 0) check("rr_spacing", n, 2);
      @(negedge clk);
    end
    clear_reqs();
    do_reset();

    // Reset during EXEC discards the operation and restores the pointer.
    do_reset();
    set_req(1'b1, 2'b00, 8'd200, 8'd100);
    #1;
    check("mid_accept", req1_ready, 1);
    @(negedge clk);
    clear_reqs();
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu", {alu_opcode, alu_data_a, alu_data_b}, 0);
    check("mid_rst_rsp", {rsp_valid, rsp_data, rsp_id, rsp_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
`ifdef ALU_SCHED_STATS_EN
    exp_g0 = 0; exp_g1 = 0; exp_d0 = 0;
`endif
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("mid_no_rsp", n, 0);
    set_req(1'b0, 2'b00, 8'd1, 8'd1);
    set_req(1'b1, 2'b00, 8'd2, 8'd2);
    #1;
    check("mid_tie", {req1_ready, req0_ready}, 2'b01);
    note_grant(1'b0, 1'b0);
    @(negedge clk);
    clear_reqs();
    collect(1'b0, 8'd2, 1'b0, 0);

    // Randomised traffic against the transaction-level model.
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      pat = $urandom_range(1, 3);
      op0 = 2'($urandom); op1 = 2'($urandom);
      x0 = 8'($urandom); x1 = 8'($urandom);
      y0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      y1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      if (pat[0]) set_req(1'b0, op0, x0, y0);
      if (pat[1]) set_req(1'b1, op1, x1, y1);
      w = (pat == 1) ? 1'b0 : (pat == 2) ? 1'b1 : !model_last;
      #1;
      check("rand_grant", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
      if (w) ref_op(op1, x1, y1, d, e);
      else   ref_op(op0, x0, y0, d, e);
      note_grant(w, e);
      @(negedge clk);
      req0_data_a = ~req0_data_a;
      req1_data_b = ~req1_data_b;
      @(posedge clk);
      @(negedge clk);
      clear_reqs();
      n = 0;
      check("rand_valid", rsp_valid, 1);
      check("rand_data", rsp_data, d);
      check("rand_id_err", {rsp_id, rsp_err}, {w, e});
      rsp_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rand_hold", {rsp_valid, rsp_data}, {1'b1, d});
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rand_drop", rsp_valid, 0);
      model_last = w;
    end
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;

`ifdef ALU_SCHED_STATS_EN
    check("stat_gnt0", stat_gnt0, exp_g0);
    check("stat_gnt1", stat_gnt1, exp_g1);
    check("stat_div0", stat_div0, exp_d0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
